// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the memory stage and the data memory.
// The LSU drives the request side (master); the memory answers (slave).
interface mem_stage_lsu_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output dmem_be,
      input  dmem_rdata,
      input  dmem_ack
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_be,
      output dmem_rdata,
      output dmem_ack
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage RV32I pipeline.
// Issues loads/stores on a req/ack data port with byte-lane steering, extends load
// data, stalls the front of the pipe while an access is outstanding, aborts a
// hung access with a watchdog, and owns the M/W pipeline register.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 255   // wait cycles before abort; 0 disables
) (
   input  logic            clk,
   input  logic            rst_n,
   // E/M pipeline register
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [2:0]      funct3M,
   input  logic [31:0]     ALUResultM,
   input  logic [31:0]     WriteDataM,
   input  logic [31:0]     PCPlus4M,
   input  logic [4:0]      RdM,
   // data-memory port
   mem_stage_lsu_if.master dmem,
   // hazard control
   output logic            StallM,
   // M/W pipeline register
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [31:0]     ALUResultW,
   output logic [31:0]     ReadDataW,
   output logic [31:0]     PCPlus4W,
   output logic [4:0]      RdW,
   output logic            lsu_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   // Last count value before the watchdog fires; TIMEOUT=0 never fires.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
   localparam bit         WDOG_EN   = (TIMEOUT != 0);

   state_t      state_q, state_d;
   logic [7:0]  wdog_q, wdog_d;

   logic        mem_op;
   logic        misaligned;
   logic        in_service;
   logic        req_on;
   logic        req_gate;
   logic [3:0]  be_raw;
   logic [31:0] wdata_raw;
   logic [31:0] load_lane;
   logic [31:0] load_ext;

   logic        regwrite_d;
   logic [1:0]  resultsrc_d;
   logic [31:0] aluresult_d;
   logic [31:0] readdata_d;
   logic [31:0] pcplus4_d;
   logic [4:0]  rd_d;
   logic        err_d;

   // Classify the instruction in M: is it a memory op, and is it aligned for its size.
   always_comb begin
      mem_op     = MemWriteM | (ResultSrcM == 2'b01);
      misaligned = 1'b0;
      case (funct3M[1:0])
         2'b01:   misaligned = ALUResultM[0];
         2'b10:   misaligned = |ALUResultM[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   // A request is only live while the FSM can accept one; ABORT drops it.
   assign in_service = (state_q == S_IDLE) || (state_q == S_WAIT);
   assign req_on     = mem_op & ~misaligned & in_service;
   // Reset kills the request immediately, independent of the clock.
   assign req_gate   = req_on & rst_n;
   assign StallM     = req_on & ~dmem.dmem_ack;

   // Byte enables and lane-replicated store data by access size.
   always_comb begin
      be_raw    = 4'b1111;
      wdata_raw = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            be_raw    = 4'b0001 << ALUResultM[1:0];
            wdata_raw = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be_raw    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata_raw = {2{WriteDataM[15:0]}};
         end
         default: begin
            be_raw    = 4'b1111;
            wdata_raw = WriteDataM;
         end
      endcase
   end

   assign dmem.dmem_req   = req_gate;
   assign dmem.dmem_we    = req_gate & MemWriteM;
   assign dmem.dmem_addr  = req_gate ? {ALUResultM[31:2], 2'b00} : 32'd0;
   assign dmem.dmem_wdata = req_gate ? wdata_raw : 32'd0;
   assign dmem.dmem_be    = req_gate ? be_raw : 4'b0000;

   // Move the addressed byte/half down to bit 0 before extending.
   assign load_lane = dmem.dmem_rdata >> {ALUResultM[1:0], 3'b000};

   // Sign- or zero-extend the selected lane according to funct3.
   always_comb begin
      case (funct3M)
         3'b000:  load_ext = {{24{load_lane[7]}},  load_lane[7:0]};
         3'b001:  load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
         3'b100:  load_ext = {24'd0, load_lane[7:0]};
         3'b101:  load_ext = {16'd0, load_lane[15:0]};
         default: load_ext = load_lane;
      endcase
   end

   // Access FSM and watchdog: IDLE issues, WAIT holds for ack, ABORT retires a hung access.
   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      case (state_q)
         S_IDLE: begin
            if (req_on && !dmem.dmem_ack) begin
               state_d = S_WAIT;
               wdog_d  = 8'd0;
            end
         end
         S_WAIT: begin
            if (!req_on || dmem.dmem_ack) begin
               // ack wins over a watchdog expiry in the same cycle
               state_d = S_IDLE;
               wdog_d  = 8'd0;
            end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
               state_d = S_ABORT;
               wdog_d  = 8'd0;
            end else begin
               wdog_d  = wdog_q + 8'd1;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
            wdog_d  = 8'd0;
         end
         default: begin
            state_d = S_IDLE;
            wdog_d  = 8'd0;
         end
      endcase
   end

   // FSM state and watchdog count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wdog_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   // M/W next value: bubble while stalled, error-forward on misalign/abort, else pass through.
   always_comb begin
      regwrite_d  = RegWriteM;
      resultsrc_d = ResultSrcM;
      aluresult_d = ALUResultM;
      readdata_d  = load_ext;
      pcplus4_d   = PCPlus4M;
      rd_d        = RdM;
      err_d       = 1'b0;
      if (StallM) begin
         regwrite_d = 1'b0;
         rd_d       = 5'd0;
      end else if ((state_q == S_ABORT) || (mem_op && misaligned)) begin
         regwrite_d = 1'b0;
         err_d      = 1'b1;
      end
   end

   // M/W pipeline register; captures every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ALUResultW <= 32'd0;
         ReadDataW  <= 32'd0;
         PCPlus4W   <= 32'd0;
         RdW        <= 5'd0;
         lsu_err    <= 1'b0;
      end else begin
         RegWriteW  <= regwrite_d;
         ResultSrcW <= resultsrc_d;
         ALUResultW <= aluresult_d;
         ReadDataW  <= readdata_d;
         PCPlus4W   <= pcplus4_d;
         RdW        <= rd_d;
         lsu_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads/stores with immediate and delayed ack,
// lane steering and extension, misalignment, watchdog abort and async reset.
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst_n;
   logic        RegWriteM;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;
   logic [4:0]  RdM;
   logic        StallM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCPlus4W;
   logic [4:0]  RdW;
   logic        lsu_err;

   int total;
   int bad;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .dmem       (bus),
      .StallM     (StallM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .lsu_err    (lsu_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_m(input logic regw, input logic memw, input logic [1:0] rsrc,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd);
      RegWriteM  = regw;
      MemWriteM  = memw;
      ResultSrcM = rsrc;
      funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      PCPlus4M   = pc4;
      RdM        = rd;
   endtask

   task automatic set_mem(input logic ack, input logic [31:0] rd);
      bus.dmem_ack   = ack;
      bus.dmem_rdata = rd;
   endtask

   // Advance to the next edge and sample registered outputs 1 time unit later.
   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   // Move to the next negedge, where new inputs are applied.
   task automatic to_neg();
      @(negedge clk);
   endtask

   // One zero-wait load: drive at negedge, check request, check W after the edge.
   task automatic load_now(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
      set_m(1'b1, 1'b0, 2'b01, f3, addr, 32'd0, addr + 32'd4, 5'd10);
      set_mem(1'b1, rdata);
      #1;
      check_val({tag, "_req"},   32'(bus.dmem_req), 32'd1);
      check_val({tag, "_stall"}, 32'(StallM),       32'd0);
      edge_sample();
      check_val({tag, "_data"},  ReadDataW,         exp);
      check_val({tag, "_rw"},    32'(RegWriteW),    32'd1);
      $display("txn %s addr=%h rdata=%h -> ReadDataW=%h", tag, addr, rdata, ReadDataW);
      to_neg();
   endtask

   initial begin
      int cyc;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set_m(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
      set_mem(1'b0, 32'd0);

      // reset state
      edge_sample();
      edge_sample();
      check_val("rst_req",  32'(bus.dmem_req), 32'd0);
      check_val("rst_rw",   32'(RegWriteW),    32'd0);
      check_val("rst_rd",   32'(RdW),          32'd0);
      check_val("rst_err",  32'(lsu_err),      32'd0);
      check_val("rst_stall",32'(StallM),       32'd0);
      $display("txn reset");
      to_neg();
      rst_n = 1'b1;

      // LW, zero-wait
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'd0, 32'h104, 5'd5);
      set_mem(1'b1, 32'hDEADBEEF);
      #1;
      check_val("lw_req",   32'(bus.dmem_req),  32'd1);
      check_val("lw_we",    32'(bus.dmem_we),   32'd0);
      check_val("lw_addr",  bus.dmem_addr,      32'h100);
      check_val("lw_be",    32'(bus.dmem_be),   32'hF);
      check_val("lw_stall", 32'(StallM),        32'd0);
      edge_sample();
      check_val("lw_data",  ReadDataW,          32'hDEADBEEF);
      check_val("lw_rw",    32'(RegWriteW),     32'd1);
      check_val("lw_rd",    32'(RdW),           32'd5);
      check_val("lw_src",   32'(ResultSrcW),    32'd1);
      check_val("lw_pc4",   PCPlus4W,           32'h104);
      check_val("lw_err",   32'(lsu_err),       32'd0);
      $display("txn LW addr=100 -> ReadDataW=%h", ReadDataW);
      to_neg();

      // lane select and extension
      load_now("lb",  3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
      load_now("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
      load_now("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
      load_now("lh",  3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
      load_now("lb0", 3'b000, 32'h101, 32'h80112233, 32'h00000022);

      // SB and SH lane steering
      set_m(1'b0, 1'b1, 2'b00, 3'b000, 32'h201, 32'h000000AB, 32'h8, 5'd0);
      set_mem(1'b1, 32'd0);
      #1;
      check_val("sb_we",    32'(bus.dmem_we),   32'd1);
      check_val("sb_be",    32'(bus.dmem_be),   32'b0010);
      check_val("sb_wdata", bus.dmem_wdata,     32'hABABABAB);
      check_val("sb_addr",  bus.dmem_addr,      32'h200);
      edge_sample();
      check_val("sb_rw",    32'(RegWriteW),     32'd0);
      $display("txn SB addr=201 be=0010");
      to_neg();
      set_m(1'b0, 1'b1, 2'b00, 3'b001, 32'h202, 32'h00001234, 32'hC, 5'd0);
      #1;
      check_val("sh_be",    32'(bus.dmem_be),   32'b1100);
      check_val("sh_wdata", bus.dmem_wdata,     32'h12341234);
      edge_sample();
      $display("txn SH addr=202 be=1100");
      to_neg();

      // LW with ack delayed 3 cycles
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'd0, 32'h304, 5'd7);
      set_mem(1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("dly_stall", 32'(StallM),       32'd1);
         check_val("dly_req",   32'(bus.dmem_req), 32'd1);
         edge_sample();
         check_val("dly_bub_rw", 32'(RegWriteW),   32'd0);
         check_val("dly_bub_rd", 32'(RdW),         32'd0);
         to_neg();
      end
      set_mem(1'b1, 32'h12345678);
      #1;
      check_val("dly_stall_end", 32'(StallM), 32'd0);
      edge_sample();
      check_val("dly_data", ReadDataW,       32'h12345678);
      check_val("dly_rw",   32'(RegWriteW),  32'd1);
      check_val("dly_rd",   32'(RdW),        32'd7);
      $display("txn LW delayed-ack addr=300 -> ReadDataW=%h", ReadDataW);
      to_neg();

      // timeout: IDLE issue cycle + 4 WAIT cycles of stall, then ABORT
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h400, 32'd0, 32'h404, 5'd9);
      set_mem(1'b0, 32'd0);
      #1;
      cyc = 0;
      while (StallM === 1'b1 && cyc < 20) begin
         edge_sample();
         to_neg();
         #1;
         cyc++;
      end
      check_val("to_stall_cycles", 32'(cyc), 32'd5);
      check_val("to_abort_req",    32'(bus.dmem_req), 32'd0);
      set_mem(1'b1, 32'hCAFEF00D);  // stray ack in ABORT must be ignored
      edge_sample();
      check_val("to_err",  32'(lsu_err),   32'd1);
      check_val("to_rw",   32'(RegWriteW), 32'd0);
      check_val("to_rd",   32'(RdW),       32'd9);
      $display("txn LW timeout addr=400 err=%0b", lsu_err);
      to_neg();
      // non-memory op after abort: no request, 1-cycle pass-through, error cleared
      set_m(1'b1, 1'b0, 2'b00, 3'b000, 32'h55, 32'd0, 32'h20, 5'd3);
      set_mem(1'b0, 32'd0);
      #1;
      check_val("alu_req",   32'(bus.dmem_req), 32'd0);
      check_val("alu_stall", 32'(StallM),       32'd0);
      edge_sample();
      check_val("alu_err", 32'(lsu_err),   32'd0);
      check_val("alu_rw",  32'(RegWriteW), 32'd1);
      check_val("alu_res", ALUResultW,     32'h55);
      check_val("alu_rd",  32'(RdW),       32'd3);
      $display("txn ALU result=%h rd=%0d", ALUResultW, RdW);
      to_neg();

      // misaligned LW and SW
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'd0, 32'h30, 5'd4);
      set_mem(1'b1, 32'h11111111);
      #1;
      check_val("mis_lw_req",   32'(bus.dmem_req), 32'd0);
      check_val("mis_lw_stall", 32'(StallM),       32'd0);
      edge_sample();
      check_val("mis_lw_err", 32'(lsu_err),   32'd1);
      check_val("mis_lw_rw",  32'(RegWriteW), 32'd0);
      $display("txn LW misaligned addr=102 err=%0b", lsu_err);
      to_neg();
      set_m(1'b0, 1'b1, 2'b00, 3'b010, 32'h201, 32'h99, 32'h34, 5'd0);
      set_mem(1'b0, 32'd0);
      #1;
      check_val("mis_sw_req", 32'(bus.dmem_req), 32'd0);
      edge_sample();
      check_val("mis_sw_err", 32'(lsu_err), 32'd1);
      $display("txn SW misaligned addr=201 err=%0b", lsu_err);
      to_neg();

      // ack coincides with watchdog expiry: ack wins
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h500, 32'd0, 32'h504, 5'd11);
      set_mem(1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         edge_sample();
         to_neg();
      end
      set_mem(1'b1, 32'hA5A5A5A5);
      #1;
      check_val("race_stall", 32'(StallM), 32'd0);
      edge_sample();
      check_val("race_err",  32'(lsu_err),   32'd0);
      check_val("race_rw",   32'(RegWriteW), 32'd1);
      check_val("race_data", ReadDataW,      32'hA5A5A5A5);
      $display("txn LW ack-at-timeout addr=500 -> ReadDataW=%h", ReadDataW);
      to_neg();

      // async reset mid-WAIT
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h600, 32'd0, 32'h604, 5'd12);
      set_mem(1'b0, 32'd0);
      edge_sample();
      edge_sample();
      to_neg();
      check_val("mid_req_before", 32'(bus.dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_req",  32'(bus.dmem_req), 32'd0);
      check_val("mid_rst_alu",  ALUResultW,        32'd0);
      check_val("mid_rst_pc4",  PCPlus4W,          32'd0);
      check_val("mid_rst_rd",   32'(RdW),          32'd0);
      check_val("mid_rst_rdat", ReadDataW,         32'd0);
      check_val("mid_rst_err",  32'(lsu_err),      32'd0);
      $display("txn reset mid-WAIT");
      to_neg();
      rst_n = 1'b1;
      set_mem(1'b1, 32'h0BADF00D);
      #1;
      check_val("post_rst_stall", 32'(StallM), 32'd0);
      edge_sample();
      check_val("post_rst_data", ReadDataW, 32'h0BADF00D);
      $display("txn LW after reset -> ReadDataW=%h", ReadDataW);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
